// File: rtl/decode_pipe.sv
// decode_pipe: RV32I decode stage. Decodes the IF/ID instruction, reads the
// register file (with optional same-cycle write-back forwarding), builds the
// sign-extended immediate, detects load-use hazards and registers the result
// into the ID/EX pipeline register.
module decode_pipe #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int WB_BYPASS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [31:0]           if_instr,
    input  logic [XLEN-1:0]       if_pc,
    input  logic                  flush,
    input  logic                  wb_wr_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  id_stall,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_op1,
    output logic [XLEN-1:0]       ex_op2,
    output logic [XLEN-1:0]       ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [6:0]            ex_opcode,
    output logic [2:0]            ex_funct3,
    output logic [6:0]            ex_funct7,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_illegal
);

    localparam int NREGS = 2 ** REG_ADDR_W;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO  = {REG_ADDR_W{1'b0}};
    localparam logic [XLEN-1:0]       DATA_ZERO = {XLEN{1'b0}};
    localparam logic                  BYPASS_EN = (WB_BYPASS != 32'sd0);

    // Immediate for every format, sign-extended from instruction bit 31.
    // Formats without an immediate (R-type, unknown opcodes) yield zero.
    function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] ins);
        logic [31:0] raw;
        case (ins[6:0])
            OP_IALU, OP_LOAD, OP_JALR:
                raw = {{20{ins[31]}}, ins[31:20]};
            OP_STORE:
                raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OP_BRANCH:
                raw = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                raw = {ins[31:12], 12'h000};
            OP_JAL:
                raw = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:
                raw = 32'h0000_0000;
        endcase
        return XLEN'($signed(raw));
    endfunction

    logic [XLEN-1:0]       rf_r [NREGS];

    logic [6:0]            opcode_s;
    logic [REG_ADDR_W-1:0] rs1_s;
    logic [REG_ADDR_W-1:0] rs2_s;
    logic [REG_ADDR_W-1:0] rd_s;
    logic                  use_rs1_s;
    logic                  use_rs2_s;
    logic                  writes_rd_s;
    logic                  mem_read_s;
    logic                  mem_write_s;
    logic                  illegal_s;
    logic [XLEN-1:0]       op1_s;
    logic [XLEN-1:0]       op2_s;
    logic                  hazard_s;

    assign opcode_s = if_instr[6:0];
    assign rs1_s    = REG_ADDR_W'(if_instr[19:15]);
    assign rs2_s    = REG_ADDR_W'(if_instr[24:20]);
    assign rd_s     = REG_ADDR_W'(if_instr[11:7]);

    // Register file: cleared by reset, written by WB except for x0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_r[i] <= DATA_ZERO;
            end
        end else if (wb_wr_en && (wb_rd != REG_ZERO)) begin
            rf_r[wb_rd] <= wb_data;
        end
    end

    // Control decode: register usage and memory/write-back controls per opcode.
    always_comb begin
        use_rs1_s   = 1'b0;
        use_rs2_s   = 1'b0;
        writes_rd_s = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        illegal_s   = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                use_rs1_s   = 1'b1;
                use_rs2_s   = 1'b1;
                writes_rd_s = 1'b1;
            end
            OP_IALU, OP_JALR: begin
                use_rs1_s   = 1'b1;
                writes_rd_s = 1'b1;
            end
            OP_LOAD: begin
                use_rs1_s   = 1'b1;
                writes_rd_s = 1'b1;
                mem_read_s  = 1'b1;
            end
            OP_STORE: begin
                use_rs1_s   = 1'b1;
                use_rs2_s   = 1'b1;
                mem_write_s = 1'b1;
            end
            OP_BRANCH: begin
                use_rs1_s   = 1'b1;
                use_rs2_s   = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_JAL: begin
                writes_rd_s = 1'b1;
            end
            default: begin
                illegal_s   = 1'b1;
            end
        endcase
    end

    // Operand reads: x0 is hard zero, a same-cycle WB write wins when forwarding is enabled.
    always_comb begin
        op1_s = DATA_ZERO;
        op2_s = DATA_ZERO;
        if (rs1_s == REG_ZERO) begin
            op1_s = DATA_ZERO;
        end else if (BYPASS_EN && wb_wr_en && (wb_rd == rs1_s)) begin
            op1_s = wb_data;
        end else begin
            op1_s = rf_r[rs1_s];
        end
        if (rs2_s == REG_ZERO) begin
            op2_s = DATA_ZERO;
        end else if (BYPASS_EN && wb_wr_en && (wb_rd == rs2_s)) begin
            op2_s = wb_data;
        end else begin
            op2_s = rf_r[rs2_s];
        end
    end

    // Load-use hazard: the load in ID/EX targets a register the ID instruction reads.
    always_comb begin
        hazard_s = if_valid && ex_valid && ex_mem_read && (ex_rd != REG_ZERO) &&
                   ((use_rs1_s && (rs1_s == ex_rd)) || (use_rs2_s && (rs2_s == ex_rd)));
        id_stall = !rst && !flush && hazard_s;
    end

    // ID/EX register: reset clears, flush/hazard/empty slot load a bubble, otherwise capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= DATA_ZERO;
            ex_op1       <= DATA_ZERO;
            ex_op2       <= DATA_ZERO;
            ex_imm       <= DATA_ZERO;
            ex_rs1       <= REG_ZERO;
            ex_rs2       <= REG_ZERO;
            ex_rd        <= REG_ZERO;
            ex_opcode    <= 7'b0000000;
            ex_funct3    <= 3'b000;
            ex_funct7    <= 7'b0000000;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (flush || hazard_s || !if_valid) begin
            // Bubble: kill the slot and its side effects, data fields hold.
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_illegal   <= 1'b0;
        end else begin
            ex_valid     <= 1'b1;
            ex_pc        <= if_pc;
            ex_op1       <= op1_s;
            ex_op2       <= op2_s;
            ex_imm       <= imm_gen(if_instr);
            ex_rs1       <= rs1_s;
            ex_rs2       <= rs2_s;
            ex_rd        <= rd_s;
            ex_opcode    <= opcode_s;
            ex_funct3    <= if_instr[14:12];
            ex_funct7    <= if_instr[31:25];
            ex_reg_write <= writes_rd_s && (rd_s != REG_ZERO);
            ex_mem_read  <= mem_read_s;
            ex_mem_write <= mem_write_s;
            ex_illegal   <= illegal_s;
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed and randomized checks of decode_pipe against a
// format-level reference model of the RV32I decode stage.
module tb_decode_pipe;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        wb_wr_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;
    logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [6:0]  ex_opcode, ex_funct7;
    logic [2:0]  ex_funct3;

    logic        nb_id_stall, nb_ex_valid, nb_ex_reg_write, nb_ex_mem_read, nb_ex_mem_write, nb_ex_illegal;
    logic [31:0] nb_ex_pc, nb_ex_op1, nb_ex_op2, nb_ex_imm;
    logic [4:0]  nb_ex_rs1, nb_ex_rs2, nb_ex_rd;
    logic [6:0]  nb_ex_opcode, nb_ex_funct7;
    logic [2:0]  nb_ex_funct3;

    int n_cmp;
    int n_fail;

    decode_pipe #(.XLEN(32), .REG_ADDR_W(5), .WB_BYPASS(1)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1),
        .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_illegal(ex_illegal)
    );

    decode_pipe #(.XLEN(32), .REG_ADDR_W(5), .WB_BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_stall(nb_id_stall), .ex_valid(nb_ex_valid), .ex_pc(nb_ex_pc), .ex_op1(nb_ex_op1),
        .ex_op2(nb_ex_op2), .ex_imm(nb_ex_imm), .ex_rs1(nb_ex_rs1), .ex_rs2(nb_ex_rs2),
        .ex_rd(nb_ex_rd), .ex_opcode(nb_ex_opcode), .ex_funct3(nb_ex_funct3),
        .ex_funct7(nb_ex_funct7), .ex_reg_write(nb_ex_reg_write), .ex_mem_read(nb_ex_mem_read),
        .ex_mem_write(nb_ex_mem_write), .ex_illegal(nb_ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic        m_valid, m_rw, m_mr, m_mw, m_ill;
    logic [31:0] m_pc, m_op1, m_op2, m_imm, m_op1_nb, m_op2_nb;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [6:0]  m_opc, m_f7;
    logic [2:0]  m_f3;

    function automatic byte fmt_of(input logic [6:0] opc);
        case (opc)
            7'h33:               return "R";
            7'h13, 7'h03, 7'h67: return "I";
            7'h23:               return "S";
            7'h63:               return "B";
            7'h37, 7'h17:        return "U";
            7'h6F:               return "J";
            default:             return "X";
        endcase
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int s;
        s = int'(ins);
        case (fmt_of(ins[6:0]))
            "I": return 32'(s >>> 20);
            "S": return 32'((s >>> 25) * 32 + int'((ins >> 7) & 32'd31));
            "B": return 32'((s >>> 31) * 4096 + int'((ins >> 7) & 32'd1) * 2048 +
                            int'((ins >> 25) & 32'd63) * 32 + int'((ins >> 8) & 32'd15) * 2);
            "U": return ins & 32'hFFFF_F000;
            "J": return 32'((s >>> 31) * 1048576 + int'((ins >> 12) & 32'd255) * 4096 +
                            int'((ins >> 20) & 32'd1) * 2048 + int'((ins >> 21) & 32'd1023) * 2);
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit uses_rs1(input logic [31:0] ins);
        byte f;
        f = fmt_of(ins[6:0]);
        return (f == "R") || (f == "I") || (f == "S") || (f == "B");
    endfunction

    function automatic bit uses_rs2(input logic [31:0] ins);
        byte f;
        f = fmt_of(ins[6:0]);
        return (f == "R") || (f == "S") || (f == "B");
    endfunction

    function automatic bit m_hazard(input bit v, input logic [31:0] ins);
        return v && m_valid && m_mr && (m_rd != 5'd0) &&
               ((uses_rs1(ins) && ins[19:15] == m_rd) || (uses_rs2(ins) && ins[24:20] == m_rd));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx, input bit byp, input bit we,
                                           input logic [4:0] wr, input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
        if (byp && we && wr == idx) return wd;
        return m_regs[idx];
    endfunction

    task automatic model_edge(input bit r, input bit v, input logic [31:0] ins, input logic [31:0] pcv,
                              input bit fl, input bit we, input logic [4:0] wr, input logic [31:0] wd);
        byte f;
        if (r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            {m_valid, m_rw, m_mr, m_mw, m_ill} = 5'd0;
            {m_pc, m_op1, m_op2, m_imm, m_op1_nb, m_op2_nb} = '0;
            {m_rs1, m_rs2, m_rd, m_opc, m_f7, m_f3} = '0;
        end else begin
            if (fl || m_hazard(v, ins) || !v) begin
                {m_valid, m_rw, m_mr, m_mw, m_ill} = 5'd0;
            end else begin
                f        = fmt_of(ins[6:0]);
                m_valid  = 1'b1;
                m_pc     = pcv;
                m_op1    = m_read(ins[19:15], 1'b1, we, wr, wd);
                m_op2    = m_read(ins[24:20], 1'b1, we, wr, wd);
                m_op1_nb = m_read(ins[19:15], 1'b0, we, wr, wd);
                m_op2_nb = m_read(ins[24:20], 1'b0, we, wr, wd);
                m_imm    = ref_imm(ins);
                m_rs1    = ins[19:15];
                m_rs2    = ins[24:20];
                m_rd     = ins[11:7];
                m_opc    = ins[6:0];
                m_f3     = ins[14:12];
                m_f7     = ins[31:25];
                m_ill    = (f == "X");
                m_rw     = ((f == "R") || (f == "I") || (f == "U") || (f == "J")) && (m_rd != 5'd0);
                m_mr     = (m_opc == 7'h03);
                m_mw     = (m_opc == 7'h23);
            end
            if (we && wr != 5'd0) m_regs[wr] = wd;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ex();
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(m_rw));
        chk("ex_mem_read", 32'(ex_mem_read), 32'(m_mr));
        chk("ex_mem_write", 32'(ex_mem_write), 32'(m_mw));
        chk("ex_illegal", 32'(ex_illegal), 32'(m_ill));
        chk("nb_ex_valid", 32'(nb_ex_valid), 32'(m_valid));
        if (m_valid) begin
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_op1", ex_op1, m_op1);
            chk("ex_op2", ex_op2, m_op2);
            chk("ex_rs1", 32'(ex_rs1), 32'(m_rs1));
            chk("ex_rs2", 32'(ex_rs2), 32'(m_rs2));
            chk("ex_rd", 32'(ex_rd), 32'(m_rd));
            chk("ex_opcode", 32'(ex_opcode), 32'(m_opc));
            chk("ex_funct3", 32'(ex_funct3), 32'(m_f3));
            chk("ex_funct7", 32'(ex_funct7), 32'(m_f7));
            if (!m_ill) chk("ex_imm", ex_imm, m_imm);
            chk("nb_ex_op1", nb_ex_op1, m_op1_nb);
            chk("nb_ex_op2", nb_ex_op2, m_op2_nb);
        end
    endtask

    // One cycle: drive at negedge, check the combinational stall, clock, check ID/EX.
    task automatic step(input bit r, input bit v, input logic [31:0] ins, input bit fl,
                        input bit we, input logic [4:0] wr, input logic [31:0] wd, output bit st);
        logic [31:0] pcv;
        bit exp_st;
        pcv = $urandom() & 32'hFFFF_FFFC;
        @(negedge clk);
        rst = r; if_valid = v; if_instr = ins; if_pc = pcv; flush = fl;
        wb_wr_en = we; wb_rd = wr; wb_data = wd;
        #1;
        exp_st = !r && !fl && m_hazard(v, ins);
        st = id_stall;
        chk("id_stall", 32'(id_stall), 32'(exp_st));
        chk("nb_id_stall", 32'(nb_id_stall), 32'(exp_st));
        @(posedge clk);
        model_edge(r, v, ins, pcv, fl, we, wr, wd);
        #1;
        check_ex();
    endtask

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_ADDI  = 32'hFFF08113;
    localparam logic [31:0] I_X0    = 32'h00500013;
    localparam logic [31:0] I_SW    = 32'hFE20AE23;
    localparam logic [31:0] I_BEQ   = 32'hFE000CE3;
    localparam logic [31:0] I_LUI   = 32'hABCDE337;
    localparam logic [31:0] I_JAL   = 32'h001000EF;
    localparam logic [31:0] I_LW    = 32'h0000A283;
    localparam logic [31:0] I_ADD6  = 32'h00028333;
    localparam logic [31:0] I_ILL   = 32'h0000007F;

    logic [6:0] opc_pool [10];

    initial begin
        bit          st;
        bit          held;
        logic [31:0] ins;
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0; flush = 1'b0;
        wb_wr_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        opc_pool = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};

        // Reset for two cycles with a load-use-like instruction present.
        step(1'b1, 1'b1, I_LW, 1'b0, 1'b0, 5'd0, 32'd0, st);
        step(1'b1, 1'b1, I_ADD6, 1'b0, 1'b1, 5'd5, 32'h1111_1111, st);
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_op1", ex_op1, 32'd0);
        chk("rst_imm", ex_imm, 32'd0);
        chk("rst_rd", 32'(ex_rd), 32'd0);
        chk("rst_opcode", 32'(ex_opcode), 32'd0);
        chk("rst_ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal}, 32'd0);

        step(1'b0, 1'b1, I_ADD, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("add_op1", ex_op1, 32'd0);
        chk("add_op2", ex_op2, 32'd0);
        chk("add_rd", 32'(ex_rd), 32'd3);
        chk("add_rw", 32'(ex_reg_write), 32'd1);
        chk("add_valid", 32'(ex_valid), 32'd1);

        // Same-cycle write-back of x1 while decoding addi x2,x1,-1.
        step(1'b0, 1'b1, I_ADDI, 1'b0, 1'b1, 5'd1, 32'h1234_5678, st);
        chk("byp_op1", ex_op1, 32'h1234_5678);
        chk("byp_imm", ex_imm, 32'hFFFF_FFFF);
        chk("nobyp_op1", nb_ex_op1, 32'd0);

        // x0 protection.
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, st);
        step(1'b0, 1'b1, I_X0, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("x0_op1", ex_op1, 32'd0);
        chk("x0_rw", 32'(ex_reg_write), 32'd0);

        // Immediate formats.
        step(1'b0, 1'b1, I_SW, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("sw_imm", ex_imm, 32'hFFFF_FFFC);
        chk("sw_mw", 32'(ex_mem_write), 32'd1);
        chk("sw_op1", ex_op1, 32'h1234_5678);
        step(1'b0, 1'b1, I_BEQ, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("beq_imm", ex_imm, 32'hFFFF_FFF8);
        step(1'b0, 1'b1, I_LUI, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("lui_imm", ex_imm, 32'hABCD_E000);
        step(1'b0, 1'b1, I_JAL, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("jal_imm", ex_imm, 32'h0000_0800);

        // Load-use: one stall cycle with a bubble, then the add issues.
        step(1'b0, 1'b1, I_LW, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("lw_mr", 32'(ex_mem_read), 32'd1);
        step(1'b0, 1'b1, I_ADD6, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("lu_stall", 32'(st), 32'd1);
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        step(1'b0, 1'b1, I_ADD6, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("lu_nostall", 32'(st), 32'd0);
        chk("lu_issue", 32'(ex_valid), 32'd1);
        chk("lu_rd", 32'(ex_rd), 32'd6);

        // Load followed by lui: no register use, no stall.
        step(1'b0, 1'b1, I_LW, 1'b0, 1'b0, 5'd0, 32'd0, st);
        step(1'b0, 1'b1, I_LUI, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("lui_nostall", 32'(st), 32'd0);
        chk("lui_valid", 32'(ex_valid), 32'd1);

        // Flush beats hazard.
        step(1'b0, 1'b1, I_LW, 1'b0, 1'b0, 5'd0, 32'd0, st);
        step(1'b0, 1'b1, I_ADD6, 1'b1, 1'b0, 5'd0, 32'd0, st);
        chk("fl_stall", 32'(st), 32'd0);
        chk("fl_valid", 32'(ex_valid), 32'd0);

        // Reset during a stall.
        step(1'b0, 1'b1, I_LW, 1'b0, 1'b0, 5'd0, 32'd0, st);
        step(1'b1, 1'b1, I_ADD6, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("rs_stall", 32'(st), 32'd0);
        chk("rs_valid", 32'(ex_valid), 32'd0);
        step(1'b0, 1'b1, I_SW, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("rs_cleared_op1", ex_op1, 32'd0);

        // Illegal opcode advances as valid with no controls.
        step(1'b0, 1'b1, I_ILL, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("ill_flag", 32'(ex_illegal), 32'd1);
        chk("ill_valid", 32'(ex_valid), 32'd1);
        chk("ill_ctrl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);

        // Randomized traffic; IF holds the instruction while stalled.
        held = 1'b0;
        ins  = 32'd0;
        for (int n = 0; n < 600; n++) begin
            if (!held) begin
                ins = $urandom();
                ins[6:0]   = opc_pool[$urandom_range(0, 9)];
                ins[11:7]  = 5'($urandom_range(0, 3));
                ins[19:15] = 5'($urandom_range(0, 3));
                ins[24:20] = 5'($urandom_range(0, 3));
            end
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0), ins,
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 4)), $urandom(), st);
            held = st;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
